// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO PHY-side responder serving a 32x16 register file
// Ports: clk, rst_n (async, active low); mdc, mdio_i (async pad inputs);
//        mdio_o, mdio_oe (pad drive); link_up (reg 1 bit 2);
//        wr_strobe, wr_addr, wr_data (report each committed write)
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int          PRE_LEN  = 32,
  parameter logic [15:0] ID1      = 16'h0022,
  parameter logic [15:0] ID2      = 16'h1622,
  parameter logic [15:0] STATUS   = 16'h7809,
  parameter int          TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA} state_t;
  state_t state, state_nx;
  logic [2:0] mdc_q;
  logic [1:0] mdio_q;
  logic mdc_re, b, to, last, wr_en, oe_nx, o_nx, is_rd;
  logic [4:0] cnt, reg_addr;
  logic [5:0] pre_cnt;
  logic [15:0] sh, rd_val;
  logic [TW-1:0] t_cnt;
  logic [15:0] regs [32];
  assign mdc_re = mdc_q[1] & ~mdc_q[2];
  assign b = mdio_q[1];
  assign to = (t_cnt == TW'(TIMEOUT)) & ~mdc_re;
  // cnt marks the final bit of the current field
  assign last = (state inside {OP, TA}) ? cnt == 5'd1 : (state inside {PHYAD, REGAD}) ? cnt == 5'd4 : cnt == 5'd15;
  assign rd_val = reg_addr == 5'd1 ? {STATUS[15:3], link_up, STATUS[1:0]} :
                  reg_addr == 5'd2 ? ID1 : reg_addr == 5'd3 ? ID2 : regs[reg_addr];
  assign wr_en = mdc_re && state == WDATA && last && !(reg_addr inside {[5'd1:5'd3]});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (to) state_nx = IDLE;
    else if (mdc_re)
      case (state)
        IDLE:    state_nx = (!b && pre_cnt >= 6'(PRE_LEN)) ? ST : IDLE;
        ST:      state_nx = b ? OP : IDLE;
        OP:      state_nx = !last ? OP : (sh[0] != b) ? PHYAD : IDLE;
        PHYAD:   state_nx = !last ? PHYAD : ({sh[3:0], b} == PHY_ADDR) ? REGAD : IDLE;
        REGAD:   state_nx = last ? TA : REGAD;
        TA:      state_nx = !last ? ((is_rd || b) ? TA : IDLE) : is_rd ? RDATA : !b ? WDATA : IDLE;
        RDATA:   state_nx = last ? IDLE : RDATA;
        default: state_nx = last ? IDLE : WDATA;
      endcase
  end
  // TA1 sample turns the pad around driving 0; D15 follows, then RDATA walks sh
  always_comb begin
    oe_nx = mdio_oe;
    o_nx = mdio_o;
    if (to) oe_nx = 1'b0;
    else if (mdc_re && is_rd && state == TA) begin
      oe_nx = 1'b1;
      o_nx = last ? sh[15] : 1'b0;
    end else if (mdc_re && state == RDATA) begin
      oe_nx = !last;
      o_nx = sh[15];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_q <= '0;
      mdio_q <= '0;
      t_cnt <= '0;
      pre_cnt <= '0;
      cnt <= '0;
      sh <= '0;
      reg_addr <= '0;
      is_rd <= 1'b0;
      mdio_o <= 1'b0;
      mdio_oe <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      mdc_q <= {mdc_q[1:0], mdc};
      mdio_q <= {mdio_q[0], mdio_i};
      t_cnt <= mdc_re ? '0 : (t_cnt != TW'(TIMEOUT)) ? t_cnt + 1'b1 : t_cnt;
      if (to || state != IDLE) pre_cnt <= '0;
      else if (mdc_re) pre_cnt <= !b ? '0 : (pre_cnt == 6'(PRE_LEN)) ? pre_cnt : pre_cnt + 1'b1;
      if (to) cnt <= '0;
      else if (mdc_re) cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
      if (mdc_re) sh <= (is_rd && state == TA && !last) ? rd_val :
                        (is_rd && state inside {TA, RDATA}) ? {sh[14:0], 1'b0} : {sh[14:0], b};
      if (mdc_re && state == OP && last) is_rd <= sh[0];
      if (mdc_re && state == REGAD && last) reg_addr <= {sh[3:0], b};
      mdio_o <= o_nx;
      mdio_oe <= oe_nx;
      wr_strobe <= wr_en;
      if (wr_en) begin
        wr_addr <= reg_addr;
        wr_data <= {sh[14:0], b};
        regs[reg_addr] <= {sh[14:0], b};
      end
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: randomized scoreboard bench for mdio_responder
module tb_mdio_responder;
  localparam logic [15:0] ID1 = 16'h0022, ID2 = 16'h1622, STATUS = 16'h7809;
  localparam int TIMEOUT = 4096;
  typedef struct { int n; logic [16:0] bits; } rd_t;
  logic clk = 1'b0, rst_n = 1'b0, mdc = 1'b0, drv = 1'b1, link_up = 1'b0;
  logic mdio_i, mdio_o, mdio_oe, wr_strobe;
  logic [4:0] wr_addr;
  logic [15:0] wr_data;
  int n_chk = 0, n_pass = 0;
  rd_t exp_rd [$];
  logic [20:0] exp_wr [$];
  logic [15:0] model [32];
  int mon_n = 0;
  logic [16:0] mon_bits = '0;

  assign mdio_i = mdio_oe ? mdio_o : drv;
  always #5 clk = ~clk;

  mdio_responder dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .link_up(link_up), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_rd(logic [4:0] a);
    return a == 5'd1 ? ((STATUS & 16'hFFFB) | (16'(link_up) << 2)) :
           a == 5'd2 ? ID1 : a == 5'd3 ? ID2 : model[a];
  endfunction

  task automatic send_bit(logic v);
    @(negedge clk);
    mdc = 1'b0;
    drv = v;
    repeat (5) @(negedge clk);
    mdc = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame(int pre, logic rd, logic [4:0] phy, logic [4:0] ra, logic [1:0] ta, logic [15:0] d, int nd);
    logic [31:0] w;
    w = {2'b01, rd ? 2'b10 : 2'b01, phy, ra, rd ? 2'b11 : ta, rd ? 16'hFFFF : d};
    repeat (pre) send_bit(1'b1);
    for (int i = 31; i >= 16 - nd; i--) send_bit(w[i]);
  endtask

  task automatic do_write(int pre, logic [4:0] phy, logic [4:0] ra, logic [1:0] ta, logic [15:0] d);
    if (pre >= 32 && phy == 5'd1 && ta == 2'b10 && !(ra inside {[5'd1:5'd3]})) begin
      model[ra] = d;
      exp_wr.push_back({ra, d});
    end
    frame(pre, 1'b0, phy, ra, ta, d, 16);
  endtask

  task automatic do_read(int pre, logic [4:0] phy, logic [4:0] ra, int nd);
    rd_t e;
    e.n = nd + 1;
    e.bits = 17'(model_rd(ra) >> (16 - nd));
    if (pre >= 32 && phy == 5'd1) exp_rd.push_back(e);
    frame(pre, 1'b1, phy, ra, 2'b11, 16'h0, nd);
  endtask

  always @(posedge mdc)
    if (mdio_oe === 1'b1) begin
      mon_bits = {mon_bits[15:0], mdio_o};
      mon_n++;
    end

  always @(negedge mdio_oe)
    if (mon_n > 0) begin
      rd_t e;
      chk("rd_expected", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) begin
        e = exp_rd.pop_front();
        chk("rd_bits", mon_n, e.n);
        chk("rd_data", mon_bits, e.bits);
      end
      mon_n = 0;
      mon_bits = '0;
    end

  always @(negedge clk)
    if (wr_strobe === 1'b1) begin
      logic [20:0] w;
      chk("wr_expected", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        chk("wr_addr", wr_addr, w[20:16]);
        chk("wr_data", wr_data, w[15:0]);
      end
    end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_oe", mdio_oe, 0);
    chk("rst_o", mdio_o, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    do_read(32, 5'd1, 5'd2, 16);
    chk("oe_after_id", mdio_oe, 0);
    do_read(31, 5'd1, 5'd2, 16);
    chk("oe_short_pre", mdio_oe, 0);
    do_write(32, 5'd1, 5'd0, 2'b10, 16'hA5C3);
    do_read(32, 5'd1, 5'd0, 16);
    chk("wr_hold_data", wr_data, 16'hA5C3);
    do_write(32, 5'd2, 5'd4, 2'b10, 16'h1234);
    chk("oe_bad_phy", mdio_oe, 0);
    do_write(32, 5'd1, 5'd5, 2'b00, 16'h5555);
    do_read(32, 5'd1, 5'd5, 16);
    do_write(32, 5'd1, 5'd3, 2'b10, 16'hFFFF);
    do_read(32, 5'd1, 5'd3, 16);
    link_up = 1'b1;
    do_read(32, 5'd1, 5'd1, 16);
    link_up = 1'b0;
    do_read(32, 5'd1, 5'd1, 16);
    do_read(32, 5'd1, 5'd0, 5);
    repeat (TIMEOUT - 15) @(negedge clk);
    chk("oe_before_timeout", mdio_oe, 1);
    repeat (30) @(negedge clk);
    chk("oe_after_timeout", mdio_oe, 0);
    do_read(32, 5'd1, 5'd2, 16);
    repeat (24) begin
      logic [4:0] ra, phy;
      ra = 5'($urandom_range(7));
      phy = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'd1;
      link_up = 1'($urandom_range(1));
      if ($urandom_range(1) == 1) do_read(32, phy, ra, 16);
      else do_write(32, phy, ra, ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : 2'b10, 16'($urandom));
    end
    do_write(32, 5'd1, 5'd0, 2'b10, 16'h1357);
    do_read(32, 5'd1, 5'd0, 3);
    #3 rst_n = 1'b0;
    #1 chk("oe_async_reset", mdio_oe, 0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge clk);
    chk("rst2_wr_data", wr_data, 0);
    chk("rst2_wr_addr", wr_addr, 0);
    rst_n = 1'b1;
    do_read(32, 5'd1, 5'd0, 16);
    repeat (5) @(negedge clk);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
